imem_uart_loader: RTL

- Boot-time loader upstream of the single-cycle CPU's instruction memory; sits between a byte-stream receiver (UART RX) and the instruction RAM write port.
- Parses a framed program image, writes it word-by-word into instruction memory, and verifies a checksum.
- Holds the CPU in reset until a valid image has loaded, then releases it.
- Any new frame re-arms the loader and re-halts the CPU, so firmware can be reloaded in the field without a bitstream rebuild.

---
 rtl/imem_uart_loader_pkg.sv | 22 ++
 rtl/imem_uart_loader_timeout_ctr.sv | 28 ++
 rtl/imem_uart_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared encodings for the UART boot loader: FSM states, error codes and the
// default frame start marker.
package imem_uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_uart_loader_timeout_ctr.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach LIMIT.
module loader_timeout_ctr #(
   parameter int unsigned LIMIT = 1_000_000,
   parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != CNT_W'(LIMIT))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Asserted one cycle early so the consumer's registered reaction lands
   // exactly LIMIT cycles after the last clear.
   assign o_expired = i_enable && !i_clear && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: parses SYNC/LEN/payload/CSUM frames from a UART byte stream,
// writes words into instruction memory and holds the CPU in reset until verified.
module imem_uart_loader
   import imem_uart_loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_reset,
   output logic              o_load_done,
   output logic              o_load_error,
   output logic [1:0]        o_err_code,
   output logic [ADDR_W:0]   o_words_loaded
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   state_t            r_state;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_cpu_reset;
   logic              r_load_done;
   logic              r_load_error;
   logic [1:0]        r_err_code;
   logic [ADDR_W:0]   r_words_loaded;
   logic [15:0]       r_len;
   logic [1:0]        r_byte_cnt;
   logic [7:0]        r_csum;
   logic [31:0]       r_asm;
   logic              r_wr_pend;

   logic              w_active;
   logic              w_expired;
   logic              w_sync;
   logic [15:0]       w_len;
   logic              w_len_bad;
   logic              w_last_word;

   assign w_active    = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_DATA) || (r_state == ST_CSUM);
   assign w_sync      = i_rx_valid && (i_rx_data == SYNC_BYTE);
   assign w_len       = {i_rx_data, r_len[7:0]};
   assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > 17'(DEPTH));
   // Evaluated on the 4th byte, before the pending write bumps the count.
   assign w_last_word = (17'(r_words_loaded) + 17'd1) == {1'b0, r_len};

   loader_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (i_rx_valid || !w_active),
      .i_enable  (w_active),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_IDLE;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= '0;
         r_cpu_reset    <= 1'b1;
         r_load_done    <= 1'b0;
         r_load_error   <= 1'b0;
         r_err_code     <= ERR_NONE;
         r_words_loaded <= '0;
         r_len          <= '0;
         r_byte_cnt     <= '0;
         r_csum         <= '0;
         r_wr_pend      <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         // Word write runs alongside byte capture so the receiver never stalls.
         if (r_wr_pend) begin
            r_imem_we      <= 1'b1;
            r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
            r_imem_wdata   <= r_asm;
            r_words_loaded <= r_words_loaded + 1'b1;
            r_wr_pend      <= 1'b0;
         end
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (w_sync) begin
                  r_state        <= ST_LEN0;
                  r_cpu_reset    <= 1'b1;
                  r_load_done    <= 1'b0;
                  r_load_error   <= 1'b0;
                  r_err_code     <= ERR_NONE;
                  r_words_loaded <= '0;
                  r_len          <= '0;
                  r_byte_cnt     <= '0;
                  r_csum         <= '0;
               end
            end
            ST_LEN0: begin
               if (i_rx_valid) begin
                  r_len[7:0] <= i_rx_data;
                  r_state    <= ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (i_rx_valid) begin
                  r_len <= w_len;
                  if (w_len_bad) begin
                     r_state      <= ST_ERR;
                     r_load_error <= 1'b1;
                     r_err_code   <= ERR_LEN;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (i_rx_valid) begin
                  r_asm      <= {i_rx_data, r_asm[31:8]};
                  r_csum     <= r_csum + i_rx_data;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  if (r_byte_cnt == 2'd3) begin
                     r_wr_pend <= 1'b1;
                     if (w_last_word) r_state <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (i_rx_valid) begin
                  if (i_rx_data == r_csum) begin
                     r_state     <= ST_DONE;
                     r_load_done <= 1'b1;
                     r_cpu_reset <= 1'b0;
                  end else begin
                     r_state      <= ST_ERR;
                     r_load_error <= 1'b1;
                     r_err_code   <= ERR_CSUM;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_expired) begin
            r_state      <= ST_ERR;
            r_load_error <= 1'b1;
            r_err_code   <= ERR_TIMEOUT;
         end
      end
   end

   assign o_imem_we      = r_imem_we;
   assign o_imem_addr    = r_imem_addr;
   assign o_imem_wdata   = r_imem_wdata;
   assign o_cpu_reset    = r_cpu_reset;
   assign o_load_done    = r_load_done;
   assign o_load_error   = r_load_error;
   assign o_err_code     = r_err_code;
   assign o_words_loaded = r_words_loaded;

endmodule
